pe_mac_sequencer: RTL
=====================

// Module: pe_mac_sequencer
// PURPOSE
//  Sequencer for one MAC processing element (PE: 2**L_RAM_SIZE x 32b local RAM + fp MAC with psum feedback).
//  On start it runs one dot product:
//   - clears the PE accumulator;
//   - loads vector B from the global buffer (GB) into PE RAM;
//   - streams vector A from GB into the PE one element at a time, waiting for each MAC result (dvalid);
//   - returns the final psum with a done pulse. Flags a stuck MAC through a watchdog.
//  Sits between the top-level AXI control/GB and a single PE instance.
// PARAMETERS
//  L_RAM_SIZE  4                PE RAM address width; must match the PE.
//  VLEN        16               Dot-product length; 1 <= VLEN <= 2**L_RAM_SIZE.
//  GB_AW       L_RAM_SIZE+1     GB word-address width; GB[0..VLEN-1]=B, GB[VLEN..2*VLEN-1]=A.
//  TIMEOUT     64               Max cycles to wait for pe_dvalid per element before error.
// PORTS
//  aclk        in   1           Clock.
//  areset      in   1           Synchronous, active-high reset.
//  start       in   1           Start request; sampled only in IDLE.
//  busy        out  1           High in every state except IDLE.
//  done        out  1           1-cycle pulse; result valid.
//  error       out  1           Sticky watchdog flag; cleared by next accepted start or reset.
//  result      out  32          Final psum (fp32); held until next accepted start.
//  gb_addr     out  GB_AW       GB read address. GB has 1-cycle read latency.
//  gb_rdata    in   32          GB read data for gb_addr of the previous cycle.
//  pe_clear    out  1           Active-high 1-cycle PE accumulator clear.
//  pe_we       out  1           PE RAM write enable.
//  pe_addr     out  L_RAM_SIZE  PE RAM address (write, or read into bin).
//  pe_din      out  32          PE RAM write data.
//  pe_ain      out  32          PE port A operand.
//  pe_valid    out  1           PE MAC input valid (a/b/c), 1-cycle pulse per element.
//  pe_dvalid   in   1           PE MAC result valid.
//  pe_dout     in   32          PE MAC result.
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; state IDLE; counters 0.
//   - areset mid-operation aborts to IDLE with no done pulse.
//  States and transitions:
//   - IDLE: start=1 -> CLEAR; clears error and result.
//   - CLEAR (1 cycle): pe_clear=1; gb_addr=0 -> LOAD.
//   - LOAD (VLEN+1 cycles, pipelined): cycle k issues gb_addr=k (k<VLEN). Cycle k>=1 drives pe_we=1, pe_addr=k-1, pe_din=gb_rdata. After the write of index VLEN-1 -> FETCH with i=0.
//   - FETCH (1 cycle): gb_addr=VLEN+i, pe_addr=i, pe_we=0. The PE latches bin=RAM[i] at this edge -> ISSUE.
//   - ISSUE (1 cycle): pe_valid=1, pe_ain=gb_rdata (=A[i]), pe_addr held at i -> WAIT; the watchdog starts at 0.
//   - WAIT: pe_dvalid=1 -> i==VLEN-1 ? (result<=pe_dout, DONE) : (i++, FETCH). The watchdog increments each cycle; reaching TIMEOUT sets error=1 -> IDLE with no done.
//   - DONE (1 cycle): done=1 -> IDLE.
//  Rules and edge cases:
//   - Next element never issued before dvalid of the previous one (psum dependency); pe_valid never asserted outside ISSUE.
//   - pe_dvalid outside WAIT is ignored (not counted, not latched).
//   - pe_dvalid and a watchdog expiry in the same cycle: dvalid wins.
//   - start while busy, including in DONE: ignored. A start asserted in the cycle after DONE is accepted.
//   - VLEN=1: LOAD is 2 cycles, one FETCH/ISSUE/WAIT round.
//   - Latency with MAC latency M (dvalid M cycles after ISSUE): done asserts 1+(VLEN+1)+VLEN*(2+M) cycles after start is sampled, +1 for DONE.
//   - Counters: i is L_RAM_SIZE+1 bits wide (no wrap at VLEN=2**L_RAM_SIZE); the watchdog is clog2(TIMEOUT+1) bits wide and saturates.
// STRUCTURE
//  Package pe_seq_pkg:
//   - state encoding (IDLE, CLEAR, LOAD, FETCH, ISSUE, WAIT, DONE);
//   - FP32 width constant;
//   - GB base offsets (B_BASE=0, A_BASE=VLEN).
//  One sub-module, pe_seq_watchdog: clear/enable/expire counter, parameter TIMEOUT.
//  Everything else (FSM, index counters, output registers) is flat in this module.
// TESTING (bench: behavioural PE model with MAC latency M=5; GB model with 1-cycle read)
//  1. B[j]=j+1.0, A[j]=2.0, VLEN=16, start -> result=0x43880000 (272.0); done after 1+17+16*7 cycles; error=0.
//  2. Check pe_we/pe_addr/pe_din during LOAD -> PE RAM writes 0..15 in order with B values; exactly 16 pe_valid pulses, each only after the prior dvalid.
//  3. Model drops dvalid on element 3 -> error=1 after TIMEOUT=64 cycles in WAIT; no done; IDLE. A new start clears error and completes.
//  4. areset asserted in the middle of LOAD and again in the middle of WAIT -> next cycle all outputs 0 and state IDLE; a following run gives the same result as scenario 1.
//  5. start held high continuously -> back-to-back runs with exactly one IDLE cycle between done and the next CLEAR; start pulses during busy are ignored.
//  6. Spurious pe_dvalid during LOAD and FETCH -> ignored; element count and result are unchanged.

Source files
------------

// File: rtl/pe_mac_sequencer_pkg.sv
// Shared types and constants for the PE MAC sequencer: state encoding, fp32 width, GB layout.
package pe_seq_pkg;
    localparam int FP_W   = 32;
    localparam int B_BASE = 0;

    // A follows B in the global buffer, so its base depends on the vector length.
    function automatic int a_base(input int vlen);
        return B_BASE + vlen;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_FETCH, S_ISSUE, S_WAIT, S_DONE
    } state_t;
endpackage

// File: rtl/pe_mac_sequencer_if.sv
// GB read port plus PE RAM/MAC port, seen from the sequencer (master) and the GB/PE side (slave).
interface pe_mac_sequencer_if
    import pe_seq_pkg::*;
#(
    parameter int L_RAM_SIZE = 4,
    parameter int GB_AW      = L_RAM_SIZE + 1
);
    logic [GB_AW-1:0]      gb_addr;
    logic [FP_W-1:0]       gb_rdata;
    logic                  pe_clear;
    logic                  pe_we;
    logic [L_RAM_SIZE-1:0] pe_addr;
    logic [FP_W-1:0]       pe_din;
    logic [FP_W-1:0]       pe_ain;
    logic                  pe_valid;
    logic                  pe_dvalid;
    logic [FP_W-1:0]       pe_dout;

    modport master (
        output gb_addr, pe_clear, pe_we, pe_addr, pe_din, pe_ain, pe_valid,
        input  gb_rdata, pe_dvalid, pe_dout
    );
    modport slave (
        input  gb_addr, pe_clear, pe_we, pe_addr, pe_din, pe_ain, pe_valid,
        output gb_rdata, pe_dvalid, pe_dout
    );
endinterface

// File: rtl/pe_mac_sequencer_watchdog.sv
// Saturating wait counter; expire fires on the TIMEOUT-th enabled cycle after a clear.
module pe_seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != W'(TIMEOUT))
            cnt <= cnt + 1'b1;
    end

    assign expire = en && (cnt >= W'(TIMEOUT - 1));
endmodule

// File: rtl/pe_mac_sequencer.sv
// Runs one dot product on a single MAC PE: clear, load B into PE RAM, stream A, return psum.
module pe_mac_sequencer
    import pe_seq_pkg::*;
#(
    parameter int L_RAM_SIZE = 4,
    parameter int VLEN       = 16,
    parameter int GB_AW      = L_RAM_SIZE + 1,
    parameter int TIMEOUT    = 64
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [FP_W-1:0] result,
    pe_mac_sequencer_if.master bus
);
    localparam int IW = L_RAM_SIZE + 1;
    localparam logic [IW-1:0]    VLEN_I = IW'(VLEN);
    localparam logic [IW-1:0]    LAST_I = IW'(VLEN - 1);
    localparam logic [GB_AW-1:0] A_OFS  = GB_AW'(a_base(VLEN));

    state_t        state, state_nxt;
    logic [IW-1:0] k;   // LOAD cycle index: issue address k, write index k-1
    logic [IW-1:0] i;   // element index
    logic          wd_expire;

    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.gb_addr  = '0;
        bus.pe_clear = 1'b0;
        bus.pe_we    = 1'b0;
        bus.pe_addr  = '0;
        bus.pe_din   = '0;
        bus.pe_ain   = '0;
        bus.pe_valid = 1'b0;
        done         = 1'b0;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                bus.pe_clear = 1'b1;
                state_nxt    = S_LOAD;
            end
            S_LOAD: begin
                if (k < VLEN_I) bus.gb_addr = GB_AW'(B_BASE) + GB_AW'(k);
                // GB data for address k-1 arrives this cycle.
                if (k != '0) begin
                    bus.pe_we   = 1'b1;
                    bus.pe_addr = L_RAM_SIZE'(k - IW'(1));
                    bus.pe_din  = bus.gb_rdata;
                end
                if (k == VLEN_I) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.gb_addr = A_OFS + GB_AW'(i);
                bus.pe_addr = L_RAM_SIZE'(i);
                state_nxt   = S_ISSUE;
            end
            S_ISSUE: begin
                bus.pe_valid = 1'b1;
                bus.pe_ain   = bus.gb_rdata;
                bus.pe_addr  = L_RAM_SIZE'(i);
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                bus.pe_addr = L_RAM_SIZE'(i);
                // dvalid beats a simultaneous watchdog expiry.
                if (bus.pe_dvalid)  state_nxt = (i == LAST_I) ? S_DONE : S_FETCH;
                else if (wd_expire) state_nxt = S_IDLE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge aclk) begin
        if (areset) begin
            k      <= '0;
            i      <= '0;
            error  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    error  <= 1'b0;
                    result <= '0;
                end
                S_CLEAR: begin
                    k <= '0;
                    i <= '0;
                end
                S_LOAD: k <= k + 1'b1;
                S_WAIT: begin
                    if (bus.pe_dvalid) begin
                        if (i == LAST_I) result <= bus.pe_dout;
                        else             i      <= i + 1'b1;
                    end else if (wd_expire) begin
                        error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pe_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (aclk),
        .rst    (areset),
        .clr    (state == S_ISSUE),
        .en     (state == S_WAIT),
        .expire (wd_expire)
    );
endmodule
